// File: rtl/pifo_pkg.sv
// Shared configuration, FSM encoding and push-entry layout for the PIFO root scheduler.
// Every block imports its sizing from here, so this package is the single place to retune the tree.
package pifo_pkg;
    localparam int PTW        = 16;
    localparam int MTW        = 0;
    localparam int LEVEL      = 4;
    localparam int TREE_NUM   = 4;
    localparam int CAP        = 2**LEVEL - 1;
    localparam int FIFO_DEPTH = 4;

    localparam int DW   = MTW + PTW;
    localparam int TIDW = $clog2(TREE_NUM);
    localparam int CNTW = $clog2(CAP + 1);
    localparam int LVLW = $clog2(LEVEL);
    localparam int FAW  = $clog2(FIFO_DEPTH);
    localparam int PCW  = $clog2(FIFO_DEPTH + 1);

    typedef enum logic [0:0] {
        S_ISSUE   = 1'b0,
        S_POPWAIT = 1'b1
    } state_e;

    typedef struct packed {
        logic [TIDW-1:0] tree_id;
        logic [DW-1:0]   data;
    } push_entry_t;

    // Occupancy update with the push applied before the pop in the same cycle.
    function automatic logic [CNTW-1:0] cnt_update(input logic [CNTW-1:0] cnt,
                                                   input logic            inc,
                                                   input logic            dec);
        return cnt + CNTW'(inc) - CNTW'(dec);
    endfunction
endpackage

// File: rtl/pifo_push_fifo.sv
// Push buffer between host and level-0 node; also counts buffered entries per tree
// so a pending pop can wait for every earlier push to its tree.
module pifo_push_fifo
    import pifo_pkg::*;
(
    input  logic                           i_clk,
    input  logic                           i_arst_n,
    input  logic                           i_wr,
    input  push_entry_t                    i_wr_entry,
    input  logic                           i_rd,
    output push_entry_t                    o_head,
    output logic                           o_full,
    output logic                           o_empty,
    output logic [TREE_NUM-1:0][PCW-1:0]   o_pend_cnt
);
    push_entry_t                  mem_r [FIFO_DEPTH];
    logic [FAW-1:0]               wr_ptr_r;
    logic [FAW-1:0]               rd_ptr_r;
    logic [FAW:0]                 count_r;
    logic [TREE_NUM-1:0][PCW-1:0] pend_cnt_r;
    logic                         wr_en_s;
    logic                         rd_en_s;

    assign o_full     = (count_r == (FAW+1)'(FIFO_DEPTH));
    assign o_empty    = (count_r == '0);
    assign o_head     = mem_r[rd_ptr_r];
    assign o_pend_cnt = pend_cnt_r;
    assign wr_en_s    = i_wr & ~o_full;
    assign rd_en_s    = i_rd & ~o_empty;

    // Entry storage.
    always_ff @(posedge i_clk or negedge i_arst_n) begin
        if (!i_arst_n) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem_r[i] <= '0;
            end
        end else if (wr_en_s) begin
            mem_r[wr_ptr_r] <= i_wr_entry;
        end else begin
            mem_r[wr_ptr_r] <= mem_r[wr_ptr_r];
        end
    end

    // Pointers, fill level and per-tree buffered counts.
    always_ff @(posedge i_clk or negedge i_arst_n) begin
        if (!i_arst_n) begin
            wr_ptr_r   <= '0;
            rd_ptr_r   <= '0;
            count_r    <= '0;
            pend_cnt_r <= '0;
        end else begin
            wr_ptr_r <= wr_ptr_r + FAW'(wr_en_s);
            rd_ptr_r <= rd_ptr_r + FAW'(rd_en_s);
            count_r  <= count_r + (FAW+1)'(wr_en_s) - (FAW+1)'(rd_en_s);
            for (int t = 0; t < TREE_NUM; t++) begin
                pend_cnt_r[t] <= pend_cnt_r[t]
                               + PCW'(wr_en_s && (i_wr_entry.tree_id == TIDW'(t)))
                               - PCW'(rd_en_s && (o_head.tree_id == TIDW'(t)));
            end
        end
    end
endmodule

// File: rtl/pifo_root_sched.sv
// Root scheduler: buffers host pushes, holds one host pop, and serialises both onto the
// level-0 node's single command port, honouring the node's two-cycle pop occupancy.
module pifo_root_sched
    import pifo_pkg::*;
(
    input  logic                  i_clk,
    input  logic                  i_arst_n,
    input  logic                  i_push_req,
    input  logic [DW-1:0]         i_push_data,
    input  logic [TIDW-1:0]       i_push_tree_id,
    output logic                  o_push_ready,
    input  logic                  i_pop_req,
    input  logic [TIDW-1:0]       i_pop_tree_id,
    output logic                  o_pop_ready,
    output logic                  o_pop_valid,
    output logic [DW-1:0]         o_pop_data,
    output logic [TIDW-1:0]       o_pop_tree_id,
    output logic                  o_push,
    output logic                  o_pop,
    output logic [DW-1:0]         o_push_data,
    output logic [TIDW-1:0]       o_tree_id,
    output logic [LVLW-1:0]       o_level,
    output logic [LEVEL-1:0]      o_my_addr,
    input  logic [DW-1:0]         i_pop_data,
    output logic [TREE_NUM-1:0]   o_tree_empty
);
    state_e                        state_r;
    state_e                        state_s;
    logic [TREE_NUM-1:0][CNTW-1:0] resv_cnt_r;
    logic [TREE_NUM-1:0][CNTW-1:0] resv_cnt_s;
    logic [TREE_NUM-1:0]           tree_empty_r;
    logic                          pend_valid_r;
    logic [TIDW-1:0]               pend_tree_r;
    logic                          rr_pop_r;
    logic                          pop_valid_r;
    logic [DW-1:0]                 pop_data_r;
    logic [TIDW-1:0]               pop_tree_r;
    logic                          push_fire_s;
    logic                          pop_fire_s;
    logic                          push_cand_s;
    logic                          pop_cand_s;
    logic                          push_grant_s;
    logic                          pop_grant_s;
    logic [TIDW-1:0]               tree_id_s;
    push_entry_t                   wr_entry_s;
    push_entry_t                   head_s;
    logic                          fifo_full_s;
    logic                          fifo_empty_s;
    logic [TREE_NUM-1:0][PCW-1:0]  pend_cnt_s;

    assign o_push_ready  = ~fifo_full_s & (resv_cnt_r[i_push_tree_id] < CNTW'(CAP));
    assign o_pop_ready   = ~pend_valid_r & (resv_cnt_r[i_pop_tree_id] != '0);
    assign push_fire_s   = i_push_req & o_push_ready;
    assign pop_fire_s    = i_pop_req & o_pop_ready;
    assign wr_entry_s    = '{tree_id: i_push_tree_id, data: i_push_data};

    assign o_push        = push_grant_s;
    assign o_pop         = pop_grant_s;
    assign o_push_data   = push_grant_s ? head_s.data : '0;
    assign o_tree_id     = tree_id_s;
    assign o_level       = '0;
    assign o_my_addr     = '0;
    assign o_pop_valid   = pop_valid_r;
    assign o_pop_data    = pop_data_r;
    assign o_pop_tree_id = pop_tree_r;
    assign o_tree_empty  = tree_empty_r;

    pifo_push_fifo u_push_fifo (
        .i_clk      (i_clk),
        .i_arst_n   (i_arst_n),
        .i_wr       (push_fire_s),
        .i_wr_entry (wr_entry_s),
        .i_rd       (push_grant_s),
        .o_head     (head_s),
        .o_full     (fifo_full_s),
        .o_empty    (fifo_empty_s),
        .o_pend_cnt (pend_cnt_s)
    );

    // Issue arbitration; a pop only competes once no earlier push to its tree is still buffered.
    always_comb begin
        state_s      = state_r;
        push_grant_s = 1'b0;
        pop_grant_s  = 1'b0;
        push_cand_s  = ~fifo_empty_s;
        pop_cand_s   = pend_valid_r & (pend_cnt_s[pend_tree_r] == '0);
        case (state_r)
            S_ISSUE: begin
                if (push_cand_s & pop_cand_s) begin
                    pop_grant_s  = rr_pop_r;
                    push_grant_s = ~rr_pop_r;
                end else begin
                    pop_grant_s  = pop_cand_s;
                    push_grant_s = push_cand_s;
                end
                if (pop_grant_s) begin
                    state_s = S_POPWAIT;
                end else begin
                    state_s = S_ISSUE;
                end
            end
            S_POPWAIT: state_s = S_ISSUE;
            default:   state_s = S_ISSUE;
        endcase
    end

    // Tree id presented with the current node command.
    always_comb begin
        tree_id_s = '0;
        if (push_grant_s) begin
            tree_id_s = head_s.tree_id;
        end else if (pop_grant_s) begin
            tree_id_s = pend_tree_r;
        end else begin
            tree_id_s = '0;
        end
    end

    // Next per-tree reservation counts.
    always_comb begin
        resv_cnt_s = resv_cnt_r;
        for (int t = 0; t < TREE_NUM; t++) begin
            resv_cnt_s[t] = cnt_update(resv_cnt_r[t],
                                       push_fire_s && (i_push_tree_id == TIDW'(t)),
                                       pop_fire_s && (i_pop_tree_id == TIDW'(t)));
        end
    end

    // FSM state, round-robin pointer and the single pending host pop.
    always_ff @(posedge i_clk or negedge i_arst_n) begin
        if (!i_arst_n) begin
            state_r      <= S_ISSUE;
            rr_pop_r     <= 1'b0;
            pend_valid_r <= 1'b0;
            pend_tree_r  <= '0;
        end else begin
            state_r <= state_s;
            if (push_grant_s) begin
                rr_pop_r <= 1'b1;
            end else if (pop_grant_s) begin
                rr_pop_r <= 1'b0;
            end else begin
                rr_pop_r <= rr_pop_r;
            end
            if (pop_fire_s) begin
                pend_valid_r <= 1'b1;
                pend_tree_r  <= i_pop_tree_id;
            end else if (state_r == S_POPWAIT) begin
                pend_valid_r <= 1'b0;
            end else begin
                pend_valid_r <= pend_valid_r;
            end
        end
    end

    // Occupancy counters and the empty flags derived from them.
    always_ff @(posedge i_clk or negedge i_arst_n) begin
        if (!i_arst_n) begin
            resv_cnt_r   <= '0;
            tree_empty_r <= '1;
        end else begin
            resv_cnt_r <= resv_cnt_s;
            for (int t = 0; t < TREE_NUM; t++) begin
                tree_empty_r[t] <= (resv_cnt_s[t] == '0);
            end
        end
    end

    // Capture level-0 pop data during the wait cycle and pulse valid the cycle after.
    always_ff @(posedge i_clk or negedge i_arst_n) begin
        if (!i_arst_n) begin
            pop_valid_r <= 1'b0;
            pop_data_r  <= '0;
            pop_tree_r  <= '0;
        end else begin
            pop_valid_r <= (state_r == S_POPWAIT);
            if (state_r == S_POPWAIT) begin
                pop_data_r <= i_pop_data;
                pop_tree_r <= pend_tree_r;
            end else begin
                pop_data_r <= pop_data_r;
                pop_tree_r <= pop_tree_r;
            end
        end
    end
endmodule

// File: tb/tb_pifo_root_sched.sv
// Scoreboard bench for pifo_root_sched: a host-level model predicts readiness, node commands
// and returned minima; a behavioural level-0 PIFO answers the scheduler's pops.
module tb_pifo_root_sched;
    import pifo_pkg::*;

    typedef struct {
        logic [1:0]  tid;
        logic [15:0] d;
    } ent_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        push_req, pop_req;
    logic [15:0] push_data;
    logic [1:0]  push_tid, pop_tid;
    logic        push_ready, pop_ready, pop_valid;
    logic [15:0] pop_data_o, push_data_o, pop_data_i;
    logic [1:0]  pop_tid_o, tree_id_o;
    logic        cmd_push, cmd_pop;
    logic [1:0]  level_o;
    logic [3:0]  my_addr_o, tree_empty;

    int n_cmp = 0;
    int n_err = 0;

    // Host-level model state.
    ent_t        pq[$];
    ent_t        sb_q[$];
    logic [15:0] host_q[4][$];
    logic [15:0] node_q[4][$];
    int          cnt_m[4];
    bit          pend_m, popwait_m, valid_due_m, prio_push_m, drive_m, pop_seen_m;
    logic [1:0]  pend_tree_m;
    logic [15:0] drive_val_m;

    always #5 clk = ~clk;

    pifo_root_sched dut (
        .i_clk(clk), .i_arst_n(rst_n),
        .i_push_req(push_req), .i_push_data(push_data), .i_push_tree_id(push_tid),
        .o_push_ready(push_ready),
        .i_pop_req(pop_req), .i_pop_tree_id(pop_tid), .o_pop_ready(pop_ready),
        .o_pop_valid(pop_valid), .o_pop_data(pop_data_o), .o_pop_tree_id(pop_tid_o),
        .o_push(cmd_push), .o_pop(cmd_pop), .o_push_data(push_data_o), .o_tree_id(tree_id_o),
        .o_level(level_o), .o_my_addr(my_addr_o), .i_pop_data(pop_data_i),
        .o_tree_empty(tree_empty)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [15:0] take_min(input bit from_node, input int t);
        logic [15:0] v;
        int          bi;
        bi = 0;
        if (from_node) begin
            v = node_q[t][0];
            for (int i = 1; i < node_q[t].size(); i++)
                if (node_q[t][i] < v) begin v = node_q[t][i]; bi = i; end
            node_q[t].delete(bi);
        end else begin
            v = host_q[t][0];
            for (int i = 1; i < host_q[t].size(); i++)
                if (host_q[t][i] < v) begin v = host_q[t][i]; bi = i; end
            host_q[t].delete(bi);
        end
        return v;
    endfunction

    task automatic reset_model();
        pq.delete(); sb_q.delete();
        for (int t = 0; t < 4; t++) begin
            cnt_m[t] = 0; host_q[t].delete(); node_q[t].delete();
        end
        pend_m = 0; popwait_m = 0; valid_due_m = 0; prio_push_m = 1;
        drive_m = 0; pop_seen_m = 0; pend_tree_m = 2'd0;
    endtask

    // One clock of stimulus: check this cycle's outputs against the model, then drive new requests.
    task automatic cycle(input bit preq, input logic [1:0] ptid, input logic [15:0] pdata,
                         input bit oreq, input logic [1:0] otid);
        bit          in_wait, push_c, pop_c, exp_push, exp_pop, exp_pr, exp_or, drive_now, blocked;
        int          occ;
        logic [3:0]  te;
        ent_t        e;
        @(negedge clk);
        in_wait = popwait_m;
        occ     = pq.size();
        blocked = 0;
        foreach (pq[i]) if (pq[i].tid == pend_tree_m) blocked = 1;
        push_c = !in_wait && (occ > 0);
        pop_c  = !in_wait && pend_m && !blocked;
        exp_push = 0; exp_pop = 0;
        if (push_c && pop_c) begin
            exp_push = prio_push_m; exp_pop = !prio_push_m;
        end else begin
            exp_push = push_c; exp_pop = pop_c;
        end
        for (int t = 0; t < 4; t++) te[t] = (cnt_m[t] == 0);
        chk("o_push", {31'd0, cmd_push}, {31'd0, exp_push});
        chk("o_pop", {31'd0, cmd_pop}, {31'd0, exp_pop});
        chk("o_pop_valid", {31'd0, pop_valid}, {31'd0, valid_due_m});
        chk("o_tree_empty", {28'd0, tree_empty}, {28'd0, te});
        chk("o_level", {30'd0, level_o}, 32'd0);
        chk("o_my_addr", {28'd0, my_addr_o}, 32'd0);
        drive_now = drive_m;
        drive_m   = 0;
        pop_data_i = drive_now ? drive_val_m : 16'($urandom);
        if (exp_push) begin
            e = pq.pop_front();
            chk("push_tree", {30'd0, tree_id_o}, {30'd0, e.tid});
            chk("push_data", {16'd0, push_data_o}, {16'd0, e.d});
            node_q[e.tid].push_back(e.d);
            prio_push_m = 0;
        end
        if (exp_pop) begin
            chk("pop_cmd_tree", {30'd0, tree_id_o}, {30'd0, pend_tree_m});
            if (node_q[pend_tree_m].size() == 0) begin
                n_cmp++; n_err++;
                $display("FAIL node_model: pop issued to tree %0d holding no entries", pend_tree_m);
                drive_val_m = 16'd0;
            end else begin
                drive_val_m = take_min(1'b1, int'(pend_tree_m));
            end
            drive_m = 1; prio_push_m = 1;
        end
        valid_due_m = in_wait;
        popwait_m   = exp_pop;
        pop_seen_m  = exp_pop;
        push_req = preq; push_tid = ptid; push_data = pdata;
        pop_req = oreq;  pop_tid = otid;
        #1;
        exp_pr = (occ < 4) && (cnt_m[ptid] < 15);
        exp_or = !pend_m && (cnt_m[otid] != 0);
        chk("push_ready", {31'd0, push_ready}, {31'd0, exp_pr});
        chk("pop_ready", {31'd0, pop_ready}, {31'd0, exp_or});
        if (preq && exp_pr) begin
            e.tid = ptid; e.d = pdata;
            pq.push_back(e); cnt_m[ptid]++; host_q[ptid].push_back(pdata);
        end
        if (oreq && exp_or) begin
            cnt_m[otid]--; pend_m = 1; pend_tree_m = otid;
            e.tid = otid; e.d = take_min(1'b0, int'(otid));
            sb_q.push_back(e);
        end
        if (in_wait) pend_m = 0;
    endtask

    // Scoreboard monitor: every returned pop must match the oldest predicted result.
    always @(negedge clk) begin
        ent_t e;
        if (pop_valid === 1'b1) begin
            if (sb_q.size() == 0) begin
                n_cmp++; n_err++;
                $display("FAIL pop_unexpected: valid with data %0h, none outstanding", pop_data_o);
            end else begin
                e = sb_q.pop_front();
                chk("pop_data", {16'd0, pop_data_o}, {16'd0, e.d});
                chk("pop_tree", {30'd0, pop_tid_o}, {30'd0, e.tid});
            end
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        bit         preq;
        logic [1:0] ptid;
        int         guard;
        rst_n = 1'b0; push_req = 0; pop_req = 0; push_data = 16'd0;
        push_tid = 2'd0; pop_tid = 2'd0; pop_data_i = 16'd0;
        reset_model();
        repeat (3) @(posedge clk);
        #1;
        chk("rst_o_push", {31'd0, cmd_push}, 32'd0);
        chk("rst_o_pop", {31'd0, cmd_pop}, 32'd0);
        chk("rst_pop_valid", {31'd0, pop_valid}, 32'd0);
        chk("rst_pop_data", {16'd0, pop_data_o}, 32'd0);
        chk("rst_push_data", {16'd0, push_data_o}, 32'd0);
        chk("rst_tree_empty", {28'd0, tree_empty}, 32'hf);
        chk("rst_push_ready", {31'd0, push_ready}, 32'd1);
        chk("rst_pop_ready", {31'd0, pop_ready}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Single push/pop round trip on tree 2.
        cycle(1, 2'd2, 16'h0030, 0, 2'd0);
        repeat (2) cycle(0, 2'd0, 16'd0, 0, 2'd0);
        cycle(0, 2'd0, 16'd0, 1, 2'd2);
        repeat (5) cycle(0, 2'd0, 16'd0, 0, 2'd0);
        // Pop of an empty tree, then fill tree 0 to capacity.
        cycle(0, 2'd0, 16'd0, 1, 2'd1);
        for (int i = 0; i < 16; i++) cycle(1, 2'd0, 16'($urandom), 0, 2'd0);
        cycle(1, 2'd3, 16'($urandom), 0, 2'd0);
        // Buffered tree-3 pushes ahead of a tree-3 pop.
        for (int i = 0; i < 4; i++) cycle(1, 2'd3, 16'($urandom), 0, 2'd0);
        cycle(0, 2'd0, 16'd0, 1, 2'd3);
        repeat (8) cycle(0, 2'd0, 16'd0, 0, 2'd0);
        // Continuous push stream against repeated pops on another tree.
        for (int i = 0; i < 40; i++) cycle(1, 2'd3, 16'($urandom), 1, 2'd0);
        repeat (10) cycle(0, 2'd0, 16'd0, 0, 2'd0);

        // Randomised traffic.
        for (int i = 0; i < 3000; i++) begin
            preq = ($urandom_range(0, 99) < ((i < 1500) ? 70 : 15));
            ptid = 2'($urandom_range(0, 3));
            if (pend_m && (ptid == pend_tree_m)) preq = 0;
            cycle(preq, ptid, 16'($urandom), ($urandom_range(0, 99) < 60), 2'($urandom_range(0, 3)));
        end

        // Reset while the node pop is in its wait cycle.
        guard = 0;
        while ((pend_m || pq.size() != 0 || popwait_m) && guard < 200) begin
            cycle(0, 2'd0, 16'd0, 0, 2'd0);
            guard++;
        end
        cycle(1, 2'd1, 16'h1234, 0, 2'd0);
        cycle(0, 2'd0, 16'd0, 1, 2'd1);
        guard = 0;
        while (!pop_seen_m && guard < 20) begin
            cycle(0, 2'd0, 16'd0, 0, 2'd0);
            guard++;
        end
        chk("popwait_reached", {31'd0, pop_seen_m}, 32'd1);
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        reset_model();
        chk("mid_rst_o_pop", {31'd0, cmd_pop}, 32'd0);
        chk("mid_rst_o_push", {31'd0, cmd_push}, 32'd0);
        chk("mid_rst_pop_valid", {31'd0, pop_valid}, 32'd0);
        chk("mid_rst_tree_empty", {28'd0, tree_empty}, 32'hf);
        chk("mid_rst_pop_ready", {31'd0, pop_ready}, 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 10; i++) cycle(0, 2'd0, 16'd0, 1, 2'(i));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
